// File: rtl/avalon_burst_traffic_gen.sv
// Avalon-MM burst master: writes a programmed burst sequence, reads it back with
// bounded outstanding reads, and checks every returned beat against an address pattern.
module avalon_burst_traffic_gen #(
    parameter int unsigned   AW          = 32,
    parameter int unsigned   DW          = 32,
    parameter int unsigned   MEM_HIGH    = 256,
    parameter int unsigned   MAX_BURST   = 4,
    parameter int unsigned   NUM_TRANS   = 8,
    parameter int unsigned   MAX_PENDING = 2,
    parameter logic [DW-1:0] SEED        = DW'(32'hA5A5_0000),
    parameter bit            AUTORUN     = 1'b0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start_i,
    output logic [AW-1:0]   m_av_address_o,
    output logic [DW/8-1:0] m_av_byteenable_o,
    output logic            m_av_read_o,
    input  logic [DW-1:0]   m_av_readdata_i,
    output logic [7:0]      m_av_burstcount_o,
    output logic            m_av_write_o,
    output logic [DW-1:0]   m_av_writedata_o,
    input  logic            m_av_waitrequest_i,
    input  logic            m_av_readdatavalid_i,
    output logic            done_o,
    output logic            error_o,
    output logic [15:0]     err_count_o,
    output logic [AW-1:0]   first_err_addr_o
);
    localparam int unsigned   BSH        = $clog2(DW / 8);
    localparam int unsigned   TW         = (NUM_TRANS > 1) ? $clog2(NUM_TRANS) : 1;
    localparam int unsigned   PW         = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned   CW         = $clog2(MAX_PENDING + 1);
    localparam logic [AW-1:0] STRIDE     = AW'(MAX_BURST * (DW / 8));
    localparam logic [AW-1:0] WIN_TOP    = AW'(MEM_HIGH);
    localparam logic [TW-1:0] LAST_TRANS = TW'(NUM_TRANS - 1);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(MAX_PENDING - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_PENDING);
    localparam logic [7:0]    MAX_LEN    = 8'(MAX_BURST);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   trans_q, trans_d;
    logic [AW-1:0]   base_q, base_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic [7:0]      rbeat_q, rbeat_d;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            error_q, error_d;
    logic [15:0]     err_count_q, err_count_d;
    logic [AW-1:0]   first_err_q, first_err_d;
    logic            autorun_q, autorun_d;
    logic [AW-1:0]   fifo_base_q [MAX_PENDING];
    logic [7:0]      fifo_len_q  [MAX_PENDING];

    logic            wr_phase, rd_cmd, push, pop, fifo_empty, rsp_beat, mismatch, start_go;
    logic [AW-1:0]   next_base, exp_addr, head_base;
    logic [7:0]      next_len, head_len;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] addr);
        return DW'(addr) ^ SEED;
    endfunction

    assign wr_phase   = (state_q == StWr);
    assign fifo_empty = (count_q == '0);
    assign rd_cmd     = (state_q == StRd) && (count_q != FULL_CNT);
    assign push       = rd_cmd && !m_av_waitrequest_i;
    assign next_base  = (base_q + STRIDE >= WIN_TOP) ? '0 : base_q + STRIDE;
    assign next_len   = (len_q == MAX_LEN) ? 8'd1 : len_q + 8'd1;

    assign m_av_write_o      = wr_phase;
    assign m_av_read_o       = rd_cmd;
    assign m_av_address_o    = (wr_phase || rd_cmd) ? base_q : '0;
    assign m_av_burstcount_o = (wr_phase || rd_cmd) ? len_q : 8'd0;
    assign m_av_byteenable_o = {(DW/8){wr_phase || rd_cmd}};
    assign m_av_writedata_o  = wr_phase ? pattern(base_q + (AW'(beat_q) << BSH)) : '0;

    // Responses are only expected while reads can be outstanding.
    assign head_base = fifo_base_q[rptr_q];
    assign head_len  = fifo_len_q[rptr_q];
    assign exp_addr  = head_base + (AW'(rbeat_q) << BSH);
    assign rsp_beat  = ((state_q == StRd) || (state_q == StDrain)) && m_av_readdatavalid_i;
    assign mismatch  = rsp_beat && (fifo_empty || (m_av_readdata_i != pattern(exp_addr)));
    assign pop       = rsp_beat && !fifo_empty && (rbeat_q == head_len - 8'd1);

    assign done_o           = (state_q == StDone);
    assign error_o          = error_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_q;

    always_comb begin
        state_d     = state_q;
        trans_d     = trans_q;
        base_d      = base_q;
        len_d       = len_q;
        beat_d      = beat_q;
        rbeat_d     = rbeat_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        error_d     = error_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        autorun_d   = autorun_q;
        start_go    = 1'b0;

        if (push) wptr_d = (wptr_q == LAST_SLOT) ? '0 : wptr_q + PW'(1);
        if (pop) begin
            rptr_d  = (rptr_q == LAST_SLOT) ? '0 : rptr_q + PW'(1);
            rbeat_d = 8'd0;
        end else if (rsp_beat && !fifo_empty) begin
            rbeat_d = rbeat_q + 8'd1;
        end

        if (mismatch) begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (!error_q) first_err_d = fifo_empty ? '1 : exp_addr;
        end

        unique case (state_q)
            StIdle: start_go = start_i || autorun_q;
            StWr: begin
                if (!m_av_waitrequest_i) begin
                    if (beat_q == len_q - 8'd1) begin
                        beat_d = 8'd0;
                        if (trans_q == LAST_TRANS) begin
                            state_d = StRd;
                            trans_d = '0;
                            base_d  = '0;
                            len_d   = 8'd1;
                        end else begin
                            trans_d = trans_q + TW'(1);
                            base_d  = next_base;
                            len_d   = next_len;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StRd: begin
                if (push) begin
                    trans_d = trans_q + TW'(1);
                    base_d  = next_base;
                    len_d   = next_len;
                    if (trans_q == LAST_TRANS) state_d = StDrain;
                end
            end
            StDrain: if (count_d == '0) state_d = StDone;
            StDone:  start_go = start_i;
            default: state_d = StIdle;
        endcase

        if (start_go) begin
            state_d     = StWr;
            trans_d     = '0;
            base_d      = '0;
            len_d       = 8'd1;
            beat_d      = 8'd0;
            rbeat_d     = 8'd0;
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            error_d     = 1'b0;
            err_count_d = 16'd0;
            first_err_d = '0;
            autorun_d   = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            trans_q     <= '0;
            base_q      <= '0;
            len_q       <= 8'd1;
            beat_q      <= 8'd0;
            rbeat_q     <= 8'd0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            error_q     <= 1'b0;
            err_count_q <= 16'd0;
            first_err_q <= '0;
            autorun_q   <= AUTORUN;
        end else begin
            state_q     <= state_d;
            trans_q     <= trans_d;
            base_q      <= base_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            rbeat_q     <= rbeat_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            autorun_q   <= autorun_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_base_q[wptr_q] <= base_q;
            fifo_len_q[wptr_q]  <= len_q;
        end
    end

endmodule

// File: tb/tb_avalon_burst_traffic_gen.sv
// Scoreboard bench: two generator instances (defaults, and NUM_TRANS=20 with AUTORUN)
// driven by memory-backed Avalon slave models.
module tb_avalon_burst_traffic_gen;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [31:0] data;} beat_t;
    typedef struct packed {logic [31:0] addr; logic [7:0] len;} cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst1, start1, rd1, wr1, wait1, rv1, done1, err1;
    logic [31:0] addr1, rdata1, wdata1, ferr1;
    logic [3:0]  be1;
    logic [7:0]  bc1;
    logic [15:0] errc1;
    logic        rst2, start2, rd2, wr2, wait2, rv2, done2, err2;
    logic [31:0] addr2, rdata2, wdata2, ferr2;
    logic [3:0]  be2;
    logic [7:0]  bc2;
    logic [15:0] errc2;

    avalon_burst_traffic_gen #(
        .AW(32), .DW(32), .MEM_HIGH(256), .MAX_BURST(4), .NUM_TRANS(8), .MAX_PENDING(2),
        .SEED(SEED), .AUTORUN(1'b0)
    ) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst1), .start_i(start1), .m_av_address_o(addr1),
        .m_av_byteenable_o(be1), .m_av_read_o(rd1), .m_av_readdata_i(rdata1),
        .m_av_burstcount_o(bc1), .m_av_write_o(wr1), .m_av_writedata_o(wdata1),
        .m_av_waitrequest_i(wait1), .m_av_readdatavalid_i(rv1), .done_o(done1),
        .error_o(err1), .err_count_o(errc1), .first_err_addr_o(ferr1)
    );

    avalon_burst_traffic_gen #(
        .AW(32), .DW(32), .MEM_HIGH(256), .MAX_BURST(4), .NUM_TRANS(20), .MAX_PENDING(2),
        .SEED(SEED), .AUTORUN(1'b1)
    ) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst2), .start_i(start2), .m_av_address_o(addr2),
        .m_av_byteenable_o(be2), .m_av_read_o(rd2), .m_av_readdata_i(rdata2),
        .m_av_burstcount_o(bc2), .m_av_write_o(wr2), .m_av_writedata_o(wdata2),
        .m_av_waitrequest_i(wait2), .m_av_readdatavalid_i(rv2), .done_o(done2),
        .error_o(err2), .err_count_o(errc2), .first_err_addr_o(ferr2)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    beat_t exp_wr1[$];
    cmd_t  exp_rd1[$];
    beat_t exp_wr2[$];

    task automatic load_exp1();
        logic [31:0] bases [8];
        logic [7:0]  lens  [8];
        bases = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70};
        lens  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};
        exp_wr1.delete();
        exp_rd1.delete();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < int'(lens[i]); k++)
                exp_wr1.push_back('{bases[i], lens[i], (bases[i] + 32'(4 * k)) ^ SEED});
            exp_rd1.push_back('{bases[i], lens[i]});
        end
    endtask

    task automatic load_exp2();
        logic [31:0] base;
        logic [7:0]  len;
        exp_wr2.delete();
        for (int i = 0; i < 20; i++) begin
            len  = 8'((i % 4) + 1);
            base = 32'((i * 16) % 256);
            for (int k = 0; k < int'(len); k++)
                exp_wr2.push_back('{base, len, (base + 32'(4 * k)) ^ SEED});
        end
    endtask

    // ---------------- slave 1: memory, optional stalls / corruption / response hold ----
    logic [31:0] mem1 [64];
    logic [31:0] resp1[$];
    bit rand_wait = 0, corrupt = 0, hold_en = 0, hold_armed = 0;
    int hold_cnt = 0;

    initial begin
        bit          wa, ra;
        logic [31:0] a, d, ba;
        logic [7:0]  b;
        int          wbeat;
        wait1 = 1'b0; rv1 = 1'b0; rdata1 = '0; wbeat = 0;
        forever begin
            @(negedge clk);
            wa = wr1 && !wait1; ra = rd1 && !wait1; a = addr1; b = bc1; d = wdata1;
            @(posedge clk);
            #1;
            if (rst1) begin
                resp1.delete(); wbeat = 0; hold_cnt = 0;
            end else begin
                if (wa) begin
                    ba = a + 32'(4 * wbeat);
                    mem1[ba[7:2]] = d;
                    wbeat = (wbeat + 1 == int'(b)) ? 0 : wbeat + 1;
                end
                if (ra) begin
                    for (int k = 0; k < int'(b); k++) resp1.push_back(a + 32'(4 * k));
                    if (hold_en && !hold_armed) begin hold_cnt = 20; hold_armed = 1; end
                end
                if (hold_cnt > 0) hold_cnt--;
            end
            wait1 = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            if (hold_cnt == 0 && resp1.size() > 0) begin
                ba = resp1.pop_front();
                rv1 = 1'b1;
                rdata1 = mem1[ba[7:2]] ^ ((corrupt && ba == 32'h24) ? 32'h1 : 32'h0);
            end else begin
                rv1 = 1'b0; rdata1 = '0;
            end
        end
    end

    // ---------------- slave 2: zero-wait memory, 1-cycle read latency ----------------
    logic [31:0] mem2 [64];
    logic [31:0] resp2[$];

    initial begin
        bit          wa, ra;
        logic [31:0] a, d, ba;
        logic [7:0]  b;
        int          wbeat;
        wait2 = 1'b0; rv2 = 1'b0; rdata2 = '0; wbeat = 0;
        forever begin
            @(negedge clk);
            wa = wr2; ra = rd2; a = addr2; b = bc2; d = wdata2;
            @(posedge clk);
            #1;
            if (rst2) begin
                resp2.delete(); wbeat = 0;
            end else begin
                if (wa) begin
                    ba = a + 32'(4 * wbeat);
                    mem2[ba[7:2]] = d;
                    wbeat = (wbeat + 1 == int'(b)) ? 0 : wbeat + 1;
                end
                if (ra) for (int k = 0; k < int'(b); k++) resp2.push_back(a + 32'(4 * k));
            end
            if (resp2.size() > 0) begin
                ba = resp2.pop_front(); rv2 = 1'b1; rdata2 = mem2[ba[7:2]];
            end else begin
                rv2 = 1'b0; rdata2 = '0;
            end
        end
    end

    // ---------------- monitors ----------------
    bit seen_rv = 0;
    int rd_before = 0, read_while_held = 0, last_rv_cyc = 0, done_cyc = 0, wr0_len1 = 0;

    initial begin
        bit          wr_st, rd_st, done_prev;
        logic [72:0] wr_hold;
        logic [40:0] rd_hold;
        beat_t       eb;
        cmd_t        ec;
        wr_st = 0; rd_st = 0; done_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst1) begin
                if (rv1) begin seen_rv = 1; last_rv_cyc = cyc; end
                if (done1 && !done_prev) done_cyc = cyc;
                if (hold_cnt > 0 && rd_before >= 2 && rd1) read_while_held++;
                if (wr_st) check("wr_stall_stable", {wr1, addr1, bc1, wdata1}, wr_hold);
                if (rd_st) check("rd_stall_stable", {rd1, addr1, bc1}, rd_hold);
                if (wr1 && !wait1) begin
                    if (exp_wr1.size() == 0) check("wr_extra_beat", {addr1, bc1, wdata1}, 0);
                    else begin
                        eb = exp_wr1.pop_front();
                        check("wr_beat", {addr1, bc1, wdata1}, eb);
                    end
                end
                if (rd1 && !wait1) begin
                    if (!seen_rv) rd_before++;
                    if (exp_rd1.size() == 0) check("rd_extra_cmd", {addr1, bc1}, 0);
                    else begin
                        ec = exp_rd1.pop_front();
                        check("rd_cmd", {addr1, bc1}, ec);
                    end
                end
                wr_st = wr1 && wait1; wr_hold = {1'b1, addr1, bc1, wdata1};
                rd_st = rd1 && wait1; rd_hold = {1'b1, addr1, bc1};
            end
            done_prev = done1;
        end
    end

    initial begin
        beat_t eb;
        forever begin
            @(negedge clk);
            if (!rst2 && wr2) begin
                if (addr2 == 32'h0 && bc2 == 8'd1) wr0_len1++;
                if (exp_wr2.size() == 0) check("wr2_extra_beat", {addr2, bc2, wdata2}, 0);
                else begin
                    eb = exp_wr2.pop_front();
                    check("wr2_beat", {addr2, bc2, wdata2}, eb);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((which == 1) ? done1 : done2) break;
        end
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {wr1, rd1, be1, addr1, bc1, done1, err1, errc1, ferr1}, 0);
        #1 rst1 = 1'b0;

        // Zero-wait run; first write beat must appear the cycle after start.
        load_exp1();
        @(posedge clk); #1 start1 = 1'b1;
        @(negedge clk);
        check("idle_before_start", wr1, 0);
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        check("first_beat_latency", {wr1, addr1, bc1}, {1'b1, 32'h0, 8'd1});
        wait_done(1, 2000);
        check("t1_status", {done1, err1, errc1}, {1'b1, 1'b0, 16'd0});
        check("t1_queues_empty", exp_wr1.size() + exp_rd1.size(), 0);
        check("t1_mem_0x34", mem1[13], 32'hA5A5_0034);
        check("t1_done_latency", done_cyc - last_rv_cyc, 1);
        repeat (5) @(negedge clk);
        check("t1_done_held", done1, 1);

        // Random stalls on both phases; a stray start mid-write is ignored.
        rand_wait = 1;
        load_exp1();
        pulse_start1();
        repeat (6) @(posedge clk);
        check("t2_in_write", wr1 | wait1, 1);
        pulse_start1();
        wait_done(1, 3000);
        check("t2_status", {done1, err1, errc1}, {1'b1, 1'b0, 16'd0});
        check("t2_queues_empty", exp_wr1.size() + exp_rd1.size(), 0);
        rand_wait = 0;
        repeat (2) @(posedge clk);

        // Corrupted read beat at 0x24.
        corrupt = 1;
        load_exp1();
        pulse_start1();
        wait_done(1, 2000);
        check("t3_status", {done1, err1, errc1, ferr1}, {1'b1, 1'b1, 16'd1, 32'h24});
        corrupt = 0;

        // Held responses: only MAX_PENDING reads may be accepted before the first beat.
        hold_en = 1; hold_armed = 0; seen_rv = 0; rd_before = 0; read_while_held = 0;
        load_exp1();
        pulse_start1();
        @(negedge clk);
        check("start_clears_status", {done1, err1, errc1, ferr1}, 0);
        wait_done(1, 3000);
        check("t4_reads_before_rsp", rd_before, 2);
        check("t4_read_while_full", read_while_held, 0);
        check("t4_status", {done1, err1, errc1}, {1'b1, 1'b0, 16'd0});
        hold_en = 0;

        // Instance 2: AUTORUN, 20 transactions wrapping at 256 bytes.
        load_exp2(); wr0_len1 = 0;
        @(negedge clk); rst2 = 1'b0;
        wait_done(2, 2000);
        check("wrap_status", {done2, err2, errc2}, {1'b1, 1'b0, 16'd0});
        check("wrap_beats_at_0", wr0_len1, 2);
        check("wrap_queue_empty", exp_wr2.size(), 0);

        // Restart through reset, then reset again during beat 2 of burst 3.
        @(negedge clk); rst2 = 1'b1;
        @(negedge clk); load_exp2(); rst2 = 1'b0;
        begin
            bit found;
            found = 0;
            for (int n = 0; n < 500 && !found; n++) begin
                @(negedge clk);
                if (wr2 && addr2 == 32'h30 && wdata2 == (32'h38 ^ SEED)) found = 1;
            end
            check("reached_burst3_beat2", found, 1);
        end
        rst2 = 1'b1;
        @(negedge clk);
        check("midburst_reset", {wr2, rd2, be2, done2, err2, errc2, ferr2}, 0);
        load_exp2(); wr0_len1 = 0;
        rst2 = 1'b0;
        wait_done(2, 2000);
        check("autorun_restart_status", {done2, err2, errc2}, {1'b1, 1'b0, 16'd0});
        check("autorun_restart_queue", exp_wr2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avalon_burst_traffic_gen.md
Name: avalon_burst_traffic_gen

Overview:
Parametrised Avalon-MM burst master for bridge and memory benches. It issues a programmable sequence of variable-length write bursts, then reads every burst back with up to MAX_PENDING read bursts outstanding. Each returned beat is checked against an address-derived pattern, and the block reports done, error, error count and first failing address. It sits in bench/ and drives the Avalon slave side of the device under test.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width; power of two, 8 to 256
MEM_HIGH, 256, bytes of target window; must be a multiple of MAX_BURST*DW/8
MAX_BURST, 4, longest burst in beats, 1 to 255
NUM_TRANS, 8, bursts per phase, at least 1
MAX_PENDING, 2, read bursts outstanding at once, 1 to 16
SEED, 32'hA5A5_0000, DW-bit XOR mask for data pattern
AUTORUN, 0, 1 = start automatically in the first cycle after reset deasserts

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; synchronous, active-high
start_i  in  1  one-cycle start pulse, honoured only in IDLE or DONE
m_av_address_o  out  AW  byte address of first beat of burst
m_av_byteenable_o  out  DW/8  always all ones while read or write is high, else 0
m_av_read_o  out  1  read command
m_av_readdata_i  in  DW  read data
m_av_burstcount_o  out  8  beats in burst
m_av_write_o  out  1  write beat
m_av_writedata_o  out  DW  write data
m_av_waitrequest_i  in  1  slave stall
m_av_readdatavalid_i  in  1  read beat valid
done_o  out  1  sequence complete
error_o  out  1  sticky mismatch flag
err_count_o  out  16  mismatch count, saturates at 16'hFFFF
first_err_addr_o  out  AW  byte address of first mismatching beat

Behaviour:
- Reset (sync, active-high): all outputs 0; FSM to IDLE; counters and pending FIFO cleared. Reset mid-burst aborts the burst, and read and write are low on the next edge.
- Transaction i (0..NUM_TRANS-1):
  - len(i) = (i mod MAX_BURST)+1
  - base(i) = (i*MAX_BURST*DW/8) mod MEM_HIGH
  - Beat k has byte address base(i)+k*DW/8.
  - data = zero-extend(beat address) XOR SEED.
- FSM states: IDLE, WR, RD, DRAIN, DONE.
- IDLE -> WR on start_i, or on AUTORUN after reset. Starting clears error_o, err_count_o, first_err_addr_o and done_o.
- WR:
  - write=1, address=base(i), burstcount=len(i), all held constant for the whole burst.
  - writedata advances one beat per cycle with waitrequest=0.
  - After the last beat of the last transaction, move to RD with i=0. There are no idle cycles between bursts.
- RD:
  - read=1, address=base(i), burstcount=len(i), held until waitrequest=0.
  - On acceptance, push {base, len} into the pending FIFO (depth MAX_PENDING) and increment i.
  - read is deasserted while the FIFO is full.
  - After the last command is accepted, move to DRAIN.
- Read return (RD and DRAIN):
  - Each readdatavalid beat is compared against the pattern for FIFO-head base + beat index*DW/8.
  - The FIFO pops after len beats.
  - A command push and a response pop in the same cycle keep occupancy unchanged.
  - readdatavalid with the FIFO empty counts as a mismatch, with address reported as all ones.
- Mismatch: error_o=1, err_count_o+1 (saturating). first_err_addr_o is latched only on the first mismatch.
- DRAIN -> DONE when the FIFO is empty. DONE: done_o=1 and held until the next start or reset. start_i in WR, RD or DRAIN is ignored.
- Latency: first write beat is presented the cycle after start_i. done_o rises the cycle after the final readdatavalid beat.

Test Plan:
- Defaults, zero-wait slave with 1-cycle read latency, start_i pulse -> 8 write bursts with lengths 1,2,3,4,1,2,3,4 at 0x00,0x10,0x20,0x30,0x40,...,0x70 (20 beats). Beat at 0x34 carries 0xA5A5_0034. Then 8 matching read bursts; done_o=1, error_o=0, err_count_o=0.
- Random waitrequest (50%) on both phases -> address, burstcount and writedata stable while stalled; same 20 beats written; done_o=1, error_o=0.
- Slave corrupts the read beat at 0x24 -> error_o=1, err_count_o=1, first_err_addr_o=0x24, done_o still asserts.
- MAX_PENDING=2, slave holds readdatavalid for 20 cycles -> exactly 2 read commands accepted before the first response, read low meanwhile; all beats check clean.
- NUM_TRANS=20, MEM_HIGH=256 -> transaction 16 base wraps to 0x00, len 1; no errors, done_o=1.
- wb_rst_i asserted during beat 2 of write burst 3 -> write and read low next cycle, all status outputs 0. AUTORUN=1 restarts the sequence from transaction 0 after reset deasserts.
